// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit saturating counters behind a single
// access port shared between fetch lookups and resolved-branch updates.

module bht_cntr (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] d,
    output logic [1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= 2'b01;
        else if (en) q <= d;
    end
endmodule

module bht_ctrl #(
    parameter int p_num_entries = 16,
    parameter int p_idx_nbits   = $clog2(p_num_entries),
    parameter int p_max_stall   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   pred_req_val,
    output logic                   pred_req_rdy,
    input  logic [p_idx_nbits-1:0] pred_req_idx,
    output logic                   pred_resp_val,
    output logic                   pred_resp_taken,
    input  logic                   upd_val,
    output logic                   upd_rdy,
    input  logic [p_idx_nbits-1:0] upd_idx,
    input  logic                   upd_taken,
    output logic                   init_done
);
    localparam int STALL_W = $clog2(p_max_stall + 1);
    localparam logic [p_idx_nbits-1:0] LAST_IDX = p_idx_nbits'(p_num_entries - 1);
    localparam logic [STALL_W-1:0]     MAX_STALL = STALL_W'(p_max_stall);

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [p_idx_nbits-1:0] idx;
        logic                   taken;
    } upd_t;

    state_t                        state;
    logic [p_idx_nbits-1:0]        sweep_idx;
    upd_t                          pend;
    logic                          pend_val;
    logic [STALL_W-1:0]            stall_cnt;

    logic [p_num_entries-1:0][1:0] cntr_q;
    logic [p_num_entries-1:0]      we;
    logic [1:0]                    wdata;
    logic [1:0]                    cur, nxt;

    logic run, upd_grant, pred_fire, upd_fire;

    // Flush squashes every handshake in its cycle, so the ready outputs drop with it.
    assign run          = (state == S_RUN) && !flush;
    assign upd_grant    = run && pend_val && (!pred_req_val || stall_cnt == MAX_STALL);
    assign pred_req_rdy = run && !upd_grant;
    assign upd_rdy      = run && !pend_val;
    assign pred_fire    = pred_req_val && pred_req_rdy;
    assign upd_fire     = upd_val && upd_rdy;
    assign init_done    = (state == S_RUN);

    always_comb begin
        cur = cntr_q[pend.idx];
        if (pend.taken) nxt = (cur == 2'b11) ? cur : cur + 2'b01;
        else            nxt = (cur == 2'b00) ? cur : cur - 2'b01;
    end

    always_comb begin
        we    = '0;
        wdata = 2'b01;
        if (state == S_INIT && !flush) begin
            we[sweep_idx] = 1'b1;
        end else if (upd_grant) begin
            we[pend.idx] = 1'b1;
            wdata        = nxt;
        end
    end

    for (genvar i = 0; i < p_num_entries; i++) begin : g_cntr
        bht_cntr u_cntr (
            .clk   (clk),
            .reset (reset),
            .en    (we[i]),
            .d     (wdata),
            .q     (cntr_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_INIT;
            sweep_idx       <= '0;
            pend            <= '0;
            pend_val        <= 1'b0;
            stall_cnt       <= '0;
            pred_resp_val   <= 1'b0;
            pred_resp_taken <= 1'b0;
        end else if (flush) begin
            state         <= S_INIT;
            sweep_idx     <= '0;
            pend_val      <= 1'b0;
            stall_cnt     <= '0;
            pred_resp_val <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    pred_resp_val <= 1'b0;
                    sweep_idx     <= sweep_idx + p_idx_nbits'(1);
                    if (sweep_idx == LAST_IDX) state <= S_RUN;
                end
                S_RUN: begin
                    pred_resp_val <= pred_fire;
                    if (pred_fire) pred_resp_taken <= cntr_q[pred_req_idx][1];
                    if (upd_grant) begin
                        pend_val  <= 1'b0;
                        stall_cnt <= '0;
                    end else if (pend_val && pred_req_val) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                    // upd_rdy is low while pending, so a grant and a refill never coincide.
                    if (upd_fire) begin
                        pend_val   <= 1'b1;
                        pend.idx   <= upd_idx;
                        pend.taken <= upd_taken;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bht_ctrl.sv
// Directed + randomized bench for bht_ctrl against a per-entry counter model.

module tb_bht_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       pred_req_val = 1'b0;
    logic       pred_req_rdy;
    logic [3:0] pred_req_idx = '0;
    logic       pred_resp_val;
    logic       pred_resp_taken;
    logic       upd_val = 1'b0;
    logic       upd_rdy;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       init_done;

    int total = 0;
    int bad   = 0;
    int model [16];

    bht_ctrl #(.p_num_entries(16), .p_max_stall(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .pred_req_val    (pred_req_val),
        .pred_req_rdy    (pred_req_rdy),
        .pred_req_idx    (pred_req_idx),
        .pred_resp_val   (pred_resp_val),
        .pred_resp_taken (pred_resp_taken),
        .upd_val         (upd_val),
        .upd_rdy         (upd_rdy),
        .upd_idx         (upd_idx),
        .upd_taken       (upd_taken),
        .init_done       (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (model[i]) model[i] = 1;
    endtask

    function automatic int model_step(input int c, input bit taken);
        int n;
        n = taken ? c + 1 : c - 1;
        if (n > 3) n = 3;
        if (n < 0) n = 0;
        return n;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 64) begin
            next_cyc();
            n++;
        end
        chk(tag, n, 16);
        model_reset();
    endtask

    task automatic lookup_chk(input string tag, input int idx);
        pred_req_val = 1'b1;
        pred_req_idx = 4'(idx);
        @(negedge clk);
        chk({tag, "_rdy"}, pred_req_rdy, 1);
        next_cyc();
        pred_req_val = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, pred_resp_val, 1);
        chk({tag, "_tkn"}, pred_resp_taken, (model[idx] >= 2) ? 1 : 0);
        next_cyc();
    endtask

    // Update with no competing lookup: accepted this cycle, committed at the next edge.
    task automatic do_upd(input string tag, input int idx, input bit taken);
        upd_val   = 1'b1;
        upd_idx   = 4'(idx);
        upd_taken = taken;
        @(negedge clk);
        chk({tag, "_urdy"}, upd_rdy, 1);
        next_cyc();
        upd_val = 1'b0;
        next_cyc();
        model[idx] = model_step(model[idx], taken);
    endtask

    initial begin
        model_reset();
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_pred_rdy", pred_req_rdy, 0);
        chk("rst_upd_rdy", upd_rdy, 0);
        chk("rst_resp_val", pred_resp_val, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("init_pred_rdy", pred_req_rdy, 0);
        chk("init_upd_rdy", upd_rdy, 0);
        wait_init("init_cycles");

        for (int i = 0; i < 16; i++) lookup_chk("sweep_lkp", i);

        // saturation both ends on idx 5
        for (int k = 0; k < 4; k++) begin
            do_upd("sat_up", 5, 1'b1);
            lookup_chk("sat_up_lkp", 5);
        end
        for (int k = 0; k < 4; k++) begin
            do_upd("sat_dn", 5, 1'b0);
            lookup_chk("sat_dn_lkp", 5);
        end
        do_upd("sat_rise", 5, 1'b1);
        lookup_chk("sat_rise_lkp", 5);

        // starvation guard: update idx 3 against continuous lookups of idx 4
        upd_val = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
        pred_req_val = 1'b1; pred_req_idx = 4'd4;
        @(negedge clk);
        chk("stall_acc_rdy", pred_req_rdy, 1);
        next_cyc();
        upd_val = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("stall_pred_rdy", pred_req_rdy, (k == 4) ? 0 : 1);
            chk("stall_resp_val", pred_resp_val, (k == 5) ? 0 : 1);
            if (k == 1) chk("stall_upd_rdy", upd_rdy, 0);
            if (k < 5) chk("stall_resp_tkn", pred_resp_taken, (model[4] >= 2) ? 1 : 0);
            next_cyc();
        end
        pred_req_val = 1'b0;
        model[3] = model_step(model[3], 1'b1);
        lookup_chk("stall_commit_lkp", 3);

        // same-index lookup and update: response sees the old value
        upd_val = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
        pred_req_val = 1'b1; pred_req_idx = 4'd7;
        next_cyc();
        upd_val = 1'b0; pred_req_val = 1'b0;
        @(negedge clk);
        chk("same_resp_val", pred_resp_val, 1);
        chk("same_resp_old", pred_resp_taken, (model[7] >= 2) ? 1 : 0);
        next_cyc();
        model[7] = model_step(model[7], 1'b1);
        lookup_chk("same_after", 7);

        // flush with a pending update held off by lookups
        upd_val = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1;
        pred_req_val = 1'b1; pred_req_idx = 4'd0;
        next_cyc();
        upd_val = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_pred_rdy", pred_req_rdy, 0);
        chk("flush_upd_rdy", upd_rdy, 0);
        next_cyc();
        flush = 1'b0; pred_req_val = 1'b0;
        @(negedge clk);
        chk("flush_init_done", init_done, 0);
        chk("flush_after_rdy", pred_req_rdy, 0);
        wait_init("flush_cycles");
        @(negedge clk);
        chk("flush_no_pend", upd_rdy, 1);
        lookup_chk("flush_idx9", 9);
        lookup_chk("flush_idx7", 7);

        // reset in the middle of a sweep
        do_upd("pre_rst", 2, 1'b1);
        do_upd("pre_rst", 2, 1'b1);
        lookup_chk("pre_rst_lkp", 2);
        flush = 1'b1;
        next_cyc();
        flush = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_init_done", init_done, 0);
        chk("midrst_resp_tkn", pred_resp_taken, 0);
        chk("midrst_pred_rdy", pred_req_rdy, 0);
        chk("midrst_upd_rdy", upd_rdy, 0);
        next_cyc();
        reset = 1'b1;
        wait_init("midrst_cycles");
        lookup_chk("midrst_idx2", 2);

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int idx;
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) lookup_chk("rnd_lkp", idx);
            else do_upd("rnd_upd", idx, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 16; i++) lookup_chk("final_lkp", i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
